vga_drop_sequencer: RTL

Frame-level controller for the "drop" VGA effect datapath. It owns the frame counter and an explicit effect-phase state machine, and publishes per-frame effect parameters: frame index, drop centre, and the mode/zoom selects. It also decodes the beam position into the one-hot strobes that sequence the incremental squared-radius accumulators (r1/r2). It sits between `hvsync_generator` and the pixel datapath in the top-level TinyTapeout wrapper.

---
 rtl/vga_drop_pkg.sv | 55 +++++
 rtl/vga_drop_strobes.sv | 35 +++
 rtl/vga_drop_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/vga_drop_pkg.sv
// Shared types and constants for the drop-effect frame sequencer.
package vga_drop_pkg;

  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned V_DISPLAY = 480;
  localparam int unsigned CENTER_X  = 320;
  localparam int unsigned CENTER_Y  = 240;

  localparam int unsigned POS_W   = 10;
  localparam int unsigned CNT_W   = 12;
  localparam int unsigned FRAME_W = 7;
  localparam int unsigned PH_W    = 2;

  typedef enum logic [PH_W-1:0] {
    PH_PLAIN = 2'd0,
    PH_SPIN  = 2'd1,
    PH_MIX   = 2'd2,
    PH_ZOOM  = 2'd3
  } phase_t;

  typedef struct packed {
    logic mode_a;
    logic mode_b;
    logic zoom_mode;
  } sel_t;

  typedef struct packed {
    logic acc_clr;
    logic r1_seed;
    logic r1_step;
    logic r2_load;
    logic r2_seed;
    logic r2_step;
  } strobe_t;

  // Mode/zoom selects implied by each effect phase.
  function automatic sel_t phase_sel(input phase_t ph);
    sel_t s;
    s = '0;
    case (ph)
      PH_SPIN: s.mode_b = 1'b1;
      PH_MIX: begin
        s.mode_a = 1'b1;
        s.mode_b = 1'b1;
      end
      PH_ZOOM: begin
        s.mode_a    = 1'b1;
        s.zoom_mode = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/vga_drop_strobes.sv
// Combinational beam-position decoder driving the r1/r2 squared-radius accumulators.
module vga_drop_strobes
  import vga_drop_pkg::*;
#(
  parameter int unsigned H_DISPLAY = vga_drop_pkg::H_DISPLAY
) (
  input  logic [POS_W-1:0] hpos,
  input  logic [POS_W-1:0] vpos,
  input  logic             vsync,
  input  logic             display_on,
  input  logic [POS_W-1:0] center_y,
  input  logic [POS_W-1:0] offset_x,
  output strobe_t          strobes
);

  localparam logic [POS_W-1:0] H_END = POS_W'(H_DISPLAY);

  // Priority chain: at most one accumulator strobe, acc_clr is independent.
  always_comb begin
    strobes         = '0;
    strobes.acc_clr = vsync;
    if (display_on && (vpos == '0) && (hpos < center_y)) begin
      strobes.r1_seed = 1'b1;
    end else if (hpos == H_END) begin
      strobes.r2_load = 1'b1;
    end else if ((hpos > H_END) && ((hpos - H_END) <= offset_x)) begin
      strobes.r2_seed = 1'b1;
    end else if (display_on && (hpos == '0)) begin
      strobes.r1_step = 1'b1;
    end else if (display_on) begin
      strobes.r2_step = 1'b1;
    end
  end

endmodule

// File: rtl/vga_drop_sequencer.sv
// Frame counter, effect-phase FSM and per-frame parameters for the drop effect.
// Optional pause/single-step support is built when VGA_SEQ_STEP_EN is defined.
module vga_drop_sequencer
  import vga_drop_pkg::*;
#(
  parameter int unsigned START_FRAME = 300,
  parameter int unsigned DWELL       = 128,
  parameter int unsigned H_DISPLAY   = vga_drop_pkg::H_DISPLAY,
  parameter int unsigned V_DISPLAY   = vga_drop_pkg::V_DISPLAY
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [POS_W-1:0]   hpos,
  input  logic [POS_W-1:0]   vpos,
  input  logic               vsync,
  input  logic               display_on,
  input  logic               pause,
  input  logic               step,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [FRAME_W-1:0] frame,
  output logic [POS_W-1:0]   offset_x,
  output logic [POS_W-1:0]   offset_y,
  output logic [POS_W-1:0]   center_x,
  output logic [POS_W-1:0]   center_y,
  output logic [PH_W-1:0]    phase,
  output logic               mode_a,
  output logic               mode_b,
  output logic               zoom_mode,
  output logic               acc_clr,
  output logic               r1_seed,
  output logic               r1_step,
  output logic               r2_load,
  output logic               r2_seed,
  output logic               r2_step
);

  localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [CNT_W-1:0]   RST_CNT   = CNT_W'(START_FRAME % 4096);
  localparam logic [DW_W-1:0]    RST_DWELL = DW_W'(START_FRAME % DWELL);
  localparam logic [DW_W-1:0]    DWELL_MAX = DW_W'(DWELL - 1);
  localparam phase_t             RST_PHASE = phase_t'(PH_W'((START_FRAME / DWELL) % 4));
  localparam sel_t               RST_SEL   = phase_sel(RST_PHASE);
  localparam logic [FRAME_W-1:0] RST_FRAME = RST_CNT[FRAME_W-1:0];
  localparam logic [POS_W-1:0]   RST_OFFX  = POS_W'(RST_FRAME[FRAME_W-1:1]);
  localparam logic [POS_W-1:0]   RST_OFFY  = POS_W'(RST_FRAME);
  localparam logic [POS_W-1:0]   RST_CX    = POS_W'(CENTER_X) + RST_OFFX;
  localparam logic [POS_W-1:0]   RST_CY    = POS_W'(CENTER_Y) + RST_OFFY;

  phase_t             phase_q, phase_nxt;
  logic [DW_W-1:0]    dwell_q, dwell_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [FRAME_W-1:0] frame_nxt;
  logic [POS_W-1:0]   offx_nxt, offy_nxt, cx_nxt, cy_nxt;
  sel_t               sel_nxt;
  logic               vsync_q;
  logic               frame_edge;
  logic               adv_en;
  logic               adv;
  strobe_t            strb;

  // Vertical display size is informational only for this block.
  logic unused_vdisp;
  assign unused_vdisp = ^(POS_W'(V_DISPLAY));

  assign frame_edge = vsync & ~vsync_q;
  assign adv        = frame_edge & adv_en;

`ifdef VGA_SEQ_STEP_EN
  logic step_pend;

  // Remember a step request until the frame edge that consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_pend <= 1'b0;
    end else if (frame_edge) begin
      step_pend <= 1'b0;
    end else if (step) begin
      step_pend <= 1'b1;
    end
  end

  assign adv_en = ~pause | step_pend | step;
`else
  logic unused_step;
  assign unused_step = ^{pause, step};
  assign adv_en      = 1'b1;
`endif

  // State register: phase, counters and all published frame parameters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q   <= 1'b0;
      phase_q   <= RST_PHASE;
      dwell_q   <= RST_DWELL;
      frame_cnt <= RST_CNT;
      frame     <= RST_FRAME;
      offset_x  <= RST_OFFX;
      offset_y  <= RST_OFFY;
      center_x  <= RST_CX;
      center_y  <= RST_CY;
      mode_a    <= RST_SEL.mode_a;
      mode_b    <= RST_SEL.mode_b;
      zoom_mode <= RST_SEL.zoom_mode;
    end else begin
      vsync_q   <= vsync;
      phase_q   <= phase_nxt;
      dwell_q   <= dwell_nxt;
      frame_cnt <= cnt_nxt;
      frame     <= frame_nxt;
      offset_x  <= offx_nxt;
      offset_y  <= offy_nxt;
      center_x  <= cx_nxt;
      center_y  <= cy_nxt;
      mode_a    <= sel_nxt.mode_a;
      mode_b    <= sel_nxt.mode_b;
      zoom_mode <= sel_nxt.zoom_mode;
    end
  end

  // Next-state: advance counters on an enabled frame edge, step phase on dwell wrap.
  always_comb begin
    phase_nxt = phase_q;
    dwell_nxt = dwell_q;
    cnt_nxt   = frame_cnt;
    if (adv) begin
      cnt_nxt = frame_cnt + 1'b1;
      if (dwell_q == DWELL_MAX) begin
        dwell_nxt = '0;
        case (phase_q)
          PH_PLAIN: phase_nxt = PH_SPIN;
          PH_SPIN:  phase_nxt = PH_MIX;
          PH_MIX:   phase_nxt = PH_ZOOM;
          PH_ZOOM:  phase_nxt = PH_PLAIN;
          default:  phase_nxt = PH_PLAIN;
        endcase
      end else begin
        dwell_nxt = dwell_q + 1'b1;
      end
    end
    frame_nxt = cnt_nxt[FRAME_W-1:0];
    offx_nxt  = POS_W'(frame_nxt[FRAME_W-1:1]);
    offy_nxt  = POS_W'(frame_nxt);
    cx_nxt    = POS_W'(CENTER_X) + offx_nxt;
    cy_nxt    = POS_W'(CENTER_Y) + offy_nxt;
    sel_nxt   = phase_sel(phase_nxt);
  end

  assign phase = phase_q;

  // Beam-position strobe decoder using the registered frame parameters.
  vga_drop_strobes #(
    .H_DISPLAY (H_DISPLAY)
  ) u_strobes (
    .hpos       (hpos),
    .vpos       (vpos),
    .vsync      (vsync),
    .display_on (display_on),
    .center_y   (center_y),
    .offset_x   (offset_x),
    .strobes    (strb)
  );

  assign acc_clr = strb.acc_clr;
  assign r1_seed = strb.r1_seed;
  assign r1_step = strb.r1_step;
  assign r2_load = strb.r2_load;
  assign r2_seed = strb.r2_seed;
  assign r2_step = strb.r2_step;

endmodule
